// File: rtl/throughput_monitor.sv
// throughput_monitor: hardware checker for "after a rises, b holds throughout
// N occurrences of c". Up to DEPTH overlapping attempts are tracked in slots.
// Each cycle reports how many attempts passed and failed in the previous one.
module throughput_monitor #(
  parameter int N     = 3,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(N + 1),
  localparam int RW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a,
  input  logic          b,
  input  logic          c,
  output logic [RW-1:0] pass_cnt,
  output logic [RW-1:0] fail_cnt,
  output logic [RW-1:0] active,
  output logic          overflow,
  output logic          error
);

  logic             a_prev;
  logic             rose;
  logic             found;
  logic             drop;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] pass_v;
  logic [DEPTH-1:0] fail_v;
  logic [DEPTH-1:0] free_v;
  logic [DEPTH-1:0] load_v;
  logic [DEPTH-1:0] busy_next;
  logic [CW-1:0]    count [DEPTH];
  logic [RW-1:0]    pass_sum;
  logic [RW-1:0]    fail_sum;
  logic [RW-1:0]    busy_sum;

  // Number of set bits in a slot vector; bounded by DEPTH so it fits RW bits.
  function automatic logic [RW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [RW-1:0] sum;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + RW'(v[i]);
    end
    return sum;
  endfunction

  assign rose = a & ~a_prev;

  // Per-slot verdicts. A slot loaded this cycle is not busy yet, so its own
  // launch cycle never contributes b or c (the |=> offset).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_eval
    assign pass_v[gi] = busy[gi] & b & c & (count[gi] == CW'(N - 1));
    assign fail_v[gi] = busy[gi] & ~b;
    assign free_v[gi] = ~busy[gi] | pass_v[gi] | fail_v[gi];
  end

  // Lowest-index free slot takes the new attempt; slots retiring this cycle
  // count as free so a trigger can reuse them immediately.
  always_comb begin
    load_v = '0;
    found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rose && !found && free_v[i]) begin
        load_v[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign drop      = rose & ~found;
  assign busy_next = (busy & ~pass_v & ~fail_v) | load_v;
  assign pass_sum  = popcnt(pass_v);
  assign fail_sum  = popcnt(fail_v);
  assign busy_sum  = popcnt(busy_next);

  // Per-slot c counter: restarts on load, advances on each qualifying c.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_count
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        count[gi] <= '0;
      end else if (load_v[gi]) begin
        count[gi] <= '0;
      end else if (busy[gi] && b && c && !pass_v[gi]) begin
        count[gi] <= count[gi] + CW'(1);
      end
    end
  end

  // Slot occupancy and the edge detector for a.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy   <= '0;
      a_prev <= 1'b0;
    end else begin
      busy   <= busy_next;
      a_prev <= a;
    end
  end

  // Registered result counts and sticky status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      active   <= '0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      pass_cnt <= pass_sum;
      fail_cnt <= fail_sum;
      active   <= busy_sum;
      overflow <= overflow | drop;
      error    <= error | (|fail_v);
    end
  end

endmodule

// File: tb/tb_throughput_monitor.sv
// Directed bench for throughput_monitor: each task resets the design, drives
// a short cycle-indexed waveform and checks outputs against hand-computed values.
// "At cycle k" means the value sampled just before posedge k.
module tb_throughput_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       c = 1'b0;
  logic [2:0] pass_cnt, fail_cnt, active;
  logic       overflow, error;
  logic [2:0] pass1, fail1, active1;
  logic       overflow1, error1;

  int cyc;
  int n_checks;
  int n_fail;

  throughput_monitor #(.N(3), .DEPTH(4)) u_dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .active(active),
    .overflow(overflow), .error(error)
  );

  throughput_monitor #(.N(1), .DEPTH(4)) u_dut1 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c),
    .pass_cnt(pass1), .fail_cnt(fail1), .active(active1),
    .overflow(overflow1), .error(error1)
  );

  always #5 clock = ~clock;

  // Drive inputs for cycle cyc, then move just past its posedge.
  task automatic step(input logic r, input logic ia, input logic ib, input logic ic);
    reset = r; a = ia; b = ib; c = ic;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    cyc = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    do_reset();
    n_checks += 5;
    if (pass_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_pass got=%0d exp=0", pass_cnt); end
    if (fail_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_fail got=%0d exp=0", fail_cnt); end
    if (active !== 3'd0) begin n_fail++; $display("FAIL reset_active got=%0d exp=0", active); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%0b exp=0", error); end
    $display("test_reset: cycle %0d pass=%0d fail=%0d active=%0d ovf=%0b err=%0b",
             cyc, pass_cnt, fail_cnt, active, overflow, error);
  endtask

  task automatic test_pass();
    do_reset();
    step(0, 1, 1, 0);   // cycle 1: rise
    step(0, 1, 1, 1);   // cycle 2: c #1
    step(0, 0, 1, 1);   // cycle 3: c #2
    step(0, 0, 1, 0);   // cycle 4
    n_checks++;
    if (active !== 3'd1) begin n_fail++; $display("FAIL pass_active5 got=%0d exp=1", active); end
    step(0, 0, 1, 1);   // cycle 5: c #3 -> pass
    n_checks += 3;
    if (pass_cnt !== 3'd1) begin n_fail++; $display("FAIL pass_cnt6 got=%0d exp=1", pass_cnt); end
    if (active !== 3'd0) begin n_fail++; $display("FAIL pass_active6 got=%0d exp=0", active); end
    if (fail_cnt !== 3'd0) begin n_fail++; $display("FAIL pass_fail6 got=%0d exp=0", fail_cnt); end
    step(0, 0, 1, 0);   // cycle 6
    n_checks++;
    if (pass_cnt !== 3'd0) begin n_fail++; $display("FAIL pass_cnt7 got=%0d exp=0", pass_cnt); end
    $display("test_pass: cycle %0d pass=%0d active=%0d", cyc, pass_cnt, active);
  endtask

  task automatic test_reset_abort();
    do_reset();
    for (int k = 1; k <= 6; k++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);   // cycle 7: rise
    n_checks++;
    if (active !== 3'd1) begin n_fail++; $display("FAIL abort_active8 got=%0d exp=1", active); end
    step(0, 0, 1, 1);   // cycle 8: count 1
    step(1, 0, 0, 0);   // cycle 9: reset with b low
    n_checks += 4;
    if (active !== 3'd0) begin n_fail++; $display("FAIL abort_active10 got=%0d exp=0", active); end
    if (pass_cnt !== 3'd0) begin n_fail++; $display("FAIL abort_pass10 got=%0d exp=0", pass_cnt); end
    if (fail_cnt !== 3'd0) begin n_fail++; $display("FAIL abort_fail10 got=%0d exp=0", fail_cnt); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL abort_error10 got=%0b exp=0", error); end
    step(0, 0, 0, 0);   // cycle 10
    n_checks += 3;
    if (active !== 3'd0) begin n_fail++; $display("FAIL abort_active11 got=%0d exp=0", active); end
    if (pass_cnt !== 3'd0) begin n_fail++; $display("FAIL abort_pass11 got=%0d exp=0", pass_cnt); end
    if (fail_cnt !== 3'd0) begin n_fail++; $display("FAIL abort_fail11 got=%0d exp=0", fail_cnt); end
    $display("test_reset_abort: cycle %0d active=%0d fail=%0d", cyc, active, fail_cnt);
  endtask

  task automatic test_fail();
    do_reset();
    for (int k = 1; k <= 11; k++) step(0, 0, 0, 0);
    step(0, 1, 0, 1);   // cycle 12: rise, own b/c ignored
    step(0, 1, 1, 0);   // cycle 13
    step(0, 0, 1, 1);   // cycle 14: count 1
    n_checks += 2;
    if (active !== 3'd1) begin n_fail++; $display("FAIL fail_active15 got=%0d exp=1", active); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL fail_error15 got=%0b exp=0", error); end
    step(0, 0, 0, 0);   // cycle 15: b low -> fail
    n_checks += 3;
    if (fail_cnt !== 3'd1) begin n_fail++; $display("FAIL fail_cnt16 got=%0d exp=1", fail_cnt); end
    if (error !== 1'b1) begin n_fail++; $display("FAIL fail_error16 got=%0b exp=1", error); end
    if (pass_cnt !== 3'd0) begin n_fail++; $display("FAIL fail_pass16 got=%0d exp=0", pass_cnt); end
    step(0, 0, 0, 0);   // cycle 16
    n_checks += 3;
    if (fail_cnt !== 3'd0) begin n_fail++; $display("FAIL fail_cnt17 got=%0d exp=0", fail_cnt); end
    if (error !== 1'b1) begin n_fail++; $display("FAIL fail_error17 got=%0b exp=1", error); end
    if (active !== 3'd0) begin n_fail++; $display("FAIL fail_active17 got=%0d exp=0", active); end
    $display("test_fail: cycle %0d fail=%0d err=%0b", cyc, fail_cnt, error);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 8; k++) step(0, logic'(k % 2), 1, 0);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flag9 got=%0b exp=0", overflow); end
    step(0, 1, 1, 0);   // cycle 9: fifth rise, dropped
    n_checks += 2;
    if (active !== 3'd4) begin n_fail++; $display("FAIL ovf_active10 got=%0d exp=4", active); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag10 got=%0b exp=1", overflow); end
    step(0, 0, 1, 0);   // cycle 10
    step(0, 0, 0, 0);   // cycle 11: b low fails all
    n_checks += 4;
    if (fail_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_fail12 got=%0d exp=4", fail_cnt); end
    if (active !== 3'd0) begin n_fail++; $display("FAIL ovf_active12 got=%0d exp=0", active); end
    if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error12 got=%0b exp=1", error); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag12 got=%0b exp=1", overflow); end
    $display("test_overflow: cycle %0d fail=%0d active=%0d ovf=%0b", cyc, fail_cnt, active, overflow);
  endtask

  task automatic test_joint_pass();
    do_reset();
    step(0, 1, 1, 0);   // cycle 1: rise
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);   // cycle 3: rise
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);   // cycles 5-7: c
    step(0, 0, 1, 1);
    n_checks += 2;
    if (active !== 3'd2) begin n_fail++; $display("FAIL joint_active7 got=%0d exp=2", active); end
    if (pass_cnt !== 3'd0) begin n_fail++; $display("FAIL joint_pass7 got=%0d exp=0", pass_cnt); end
    step(0, 0, 1, 1);
    n_checks += 2;
    if (pass_cnt !== 3'd2) begin n_fail++; $display("FAIL joint_pass8 got=%0d exp=2", pass_cnt); end
    if (active !== 3'd0) begin n_fail++; $display("FAIL joint_active8 got=%0d exp=0", active); end
    $display("test_joint_pass: cycle %0d pass=%0d", cyc, pass_cnt);
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(0, 1, 1, 0);   // cycle 1: rise into slot 0
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);   // cycle 3: slot 0 fails, new rise reuses it
    n_checks += 2;
    if (fail_cnt !== 3'd1) begin n_fail++; $display("FAIL b2b_fail4 got=%0d exp=1", fail_cnt); end
    if (active !== 3'd1) begin n_fail++; $display("FAIL b2b_active4 got=%0d exp=1", active); end
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);   // cycle 6: third c -> pass
    n_checks += 2;
    if (pass_cnt !== 3'd1) begin n_fail++; $display("FAIL b2b_pass7 got=%0d exp=1", pass_cnt); end
    if (fail_cnt !== 3'd0) begin n_fail++; $display("FAIL b2b_fail7 got=%0d exp=0", fail_cnt); end
    $display("test_back_to_back: cycle %0d pass=%0d active=%0d", cyc, pass_cnt, active);
  endtask

  task automatic test_n1();
    do_reset();
    step(0, 1, 0, 1);   // cycle 1: rise; b low and c high here are ignored
    n_checks++;
    if (active1 !== 3'd1) begin n_fail++; $display("FAIL n1_active2 got=%0d exp=1", active1); end
    step(0, 0, 1, 1);   // cycle 2: c -> pass
    n_checks += 3;
    if (pass1 !== 3'd1) begin n_fail++; $display("FAIL n1_pass3 got=%0d exp=1", pass1); end
    if (fail1 !== 3'd0) begin n_fail++; $display("FAIL n1_fail3 got=%0d exp=0", fail1); end
    if (active1 !== 3'd0) begin n_fail++; $display("FAIL n1_active3 got=%0d exp=0", active1); end
    $display("test_n1: cycle %0d pass=%0d active=%0d", cyc, pass1, active1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_pass();
    test_reset_abort();
    test_fail();
    test_overflow();
    test_joint_pass();
    test_back_to_back();
    test_n1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
